debounce_multi: RTL and testbench

- Parametrised N-channel debouncer for front-panel buttons and switches.
- Each channel has:
  - its own synchroniser;
  - a per-channel stability counter that restarts on any bounce;
  - a registered debounced level;
  - one-cycle rise and fall pulses;
  - an optional hold-to-repeat pulse train.
- Sits between raw FPGA pins and the control FSMs. Consumers use rise/rpt as single-cycle commands.

---
 rtl/debounce_multi.sv | 152 +++++++++++++++
 tb/tb_debounce_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel button debouncer: per-channel synchroniser, stability counter, FSM, edge and auto-repeat pulses.
// Latency: db/rise/fall change SYNC_STAGES+DB_CYCLES edges after sw is first sampled stable; no backpressure.
module debounce_multi #(
    parameter int CHANNELS     = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 1000000,
    parameter int CNT_W        = 20,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int RPT_W        = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sw,
    output logic [CHANNELS-1:0] db,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);

    typedef enum logic [1:0] {
        ZERO      = 2'd0,
        WAIT_ONE  = 2'd1,
        ONE       = 2'd2,
        WAIT_ZERO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
    localparam bit               RPT_ON     = (REPEAT_EN != 0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        state_t                 state, state_nxt;
        logic [CNT_W-1:0]       cnt, cnt_nxt;
        logic [RPT_W-1:0]       rcnt;
        logic                   rpt_phase;
        logic                   held, entered_one, rpt_hit;
        logic                   db_nxt, rise_nxt, fall_nxt;
        logic                   db_q, rise_q, fall_q, rpt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) sync <= '0;
            else       sync <= {sync[SYNC_STAGES-2:0], sw[i]};
        end

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= ZERO;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Any sample disagreeing with the pending level drops back and discards the count.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ZERO: begin
                    if (s) begin
                        state_nxt = WAIT_ONE;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_ONE: begin
                    if (!s) begin
                        state_nxt = ZERO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!s) begin
                        state_nxt = WAIT_ZERO;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_ZERO: begin
                    if (s) begin
                        state_nxt = ONE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ZERO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ZERO;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            held        = (state == ONE) || (state == WAIT_ZERO);
            entered_one = (state == WAIT_ONE) && (state_nxt == ONE);
            db_nxt      = (state_nxt == ONE) || (state_nxt == WAIT_ZERO);
            rise_nxt    = entered_one;
            fall_nxt    = (state == WAIT_ZERO) && (state_nxt == ZERO);
            rpt_hit     = RPT_ON && held && (state_nxt != ZERO) &&
                          (rcnt == (rpt_phase ? RATE_LAST : DELAY_LAST));
        end

        // rpt_phase marks that the initial delay has elapsed and the shorter rate applies.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_q      <= 1'b0;
                rise_q    <= 1'b0;
                fall_q    <= 1'b0;
                rpt_q     <= 1'b0;
                rcnt      <= '0;
                rpt_phase <= 1'b0;
            end else begin
                db_q   <= db_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
                rpt_q  <= rpt_hit;
                if (entered_one || (state_nxt == ZERO)) begin
                    rcnt      <= '0;
                    rpt_phase <= 1'b0;
                end else if (RPT_ON && held) begin
                    if (rpt_hit) begin
                        rcnt      <= '0;
                        rpt_phase <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RPT_W'(1);
                    end
                end
            end
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
        assign rpt[i]  = rpt_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bouncing against a run-length reference model.
module tb_debounce_multi;
    localparam int CH = 3, SS = 2, DB = 8, CW = 4, RD = 20, RR = 5, RW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] sw = '0;
    logic [CH-1:0] db, rise, fall, rpt;
    logic [CH-1:0] db_n, rise_n, fall_n, rpt_n;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(CW),
                     .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(RW))
    u_dut (.clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .rpt(rpt));

    debounce_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(CW),
                     .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(RW))
    u_dut_norpt (.clk(clk), .reset(reset), .sw(sw), .db(db_n), .rise(rise_n), .fall(fall_n), .rpt(rpt_n));

    int n_cmp = 0, n_err = 0;
    int edge_n = 0;

    // Reference model: pin history, current level, length of the disagreeing run, time of last rise.
    logic          hist [CH][SS];
    logic          m_db [CH];
    int            run [CH];
    int            rise_at [CH];
    int            dut_rise_at [CH];
    logic [CH-1:0] e_db, e_rise, e_fall, e_rpt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SS; k++) hist[c][k] = 1'b0;
            m_db[c] = 1'b0;
            run[c]  = 0;
        end
        e_db = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            logic s;
            int   el;
            s = hist[c][SS-1];
            for (int k = SS-1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = sw[c];
            e_rise[c] = 1'b0; e_fall[c] = 1'b0; e_rpt[c] = 1'b0;
            run[c] = (s != m_db[c]) ? run[c] + 1 : 0;
            if (run[c] == DB + 1) begin
                m_db[c] = ~m_db[c];
                run[c]  = 0;
                if (m_db[c]) begin
                    e_rise[c]  = 1'b1;
                    rise_at[c] = edge_n;
                end else begin
                    e_fall[c] = 1'b1;
                end
            end else if (m_db[c]) begin
                el = edge_n - rise_at[c];
                e_rpt[c] = (el >= RD) && ((el - RD) % RR == 0);
            end
            e_db[c] = m_db[c];
        end
    endtask

    task automatic compare_all();
        check("db", 32'(db), 32'(e_db));
        check("rise", 32'(rise), 32'(e_rise));
        check("fall", 32'(fall), 32'(e_fall));
        check("rpt", 32'(rpt), 32'(e_rpt));
        check("norpt_db", 32'(db_n), 32'(e_db));
        check("norpt_edges", 32'({rise_n, fall_n}), 32'({e_rise, e_fall}));
        check("norpt_rpt", 32'(rpt_n), 32'(0));
        for (int c = 0; c < CH; c++) if (rise[c]) dut_rise_at[c] = edge_n;
    endtask

    task automatic step(input logic [CH-1:0] v, input logic r = 1'b0);
        @(negedge clk);
        sw    = v;
        reset = r;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input logic [CH-1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v);
    endtask

    // Asserts reset between edges so the asynchronous clear is observed immediately.
    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        model_clear();
        compare_all();
        for (int k = 0; k < n; k++) step(sw, 1'b1);
    endtask

    initial begin
        int t0;
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) begin
            dut_rise_at[c] = -1;
            rise_at[c]     = 0;
        end
        model_clear();
        #2;
        do_reset(3);
        steps(3'b000, 5);

        // Clean press on channel 0
        step(3'b001);
        t0 = edge_n;
        steps(3'b001, 14);
        check("lat_press", 32'(dut_rise_at[0] - t0), 32'd10);

        // Bouncing press on channel 1
        steps(3'b011, 3); steps(3'b001, 3); steps(3'b011, 3); steps(3'b001, 3);
        step(3'b011);
        t0 = edge_n;
        steps(3'b011, 14);
        check("lat_bounce", 32'(dut_rise_at[1] - t0), 32'd10);

        // Channel 2 press, then release with a short glitch back high
        steps(3'b111, 14);
        steps(3'b011, 3); steps(3'b111, 2); steps(3'b011, 14);
        check("release_db2", 32'(db[2]), 32'd0);

        // Hold channel 0 for auto-repeat, then release
        steps(3'b011, 15);
        steps(3'b010, 20);

        // Release channel 1, then reset in the middle of its requalification
        steps(3'b000, 14);
        steps(3'b010, 7);
        do_reset(3);
        step(3'b010);
        t0 = edge_n;
        steps(3'b010, 14);
        check("lat_reset", 32'(dut_rise_at[1] - t0), 32'd10);
        steps(3'b000, 14);

        // Simultaneous press on channels 0 and 2
        step(3'b101);
        steps(3'b101, 14);
        check("simul_rise", 32'(dut_rise_at[0] - dut_rise_at[2]), 32'd0);
        steps(3'b000, 14);

        // Random bouncing with quiet stretches long enough to qualify and repeat
        v = '0;
        for (int i = 0; i < 1500; i++) begin
            if ((i % 150) < 100)
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(7) == 0) v[c] = ~v[c];
            if ($urandom_range(399) == 0) do_reset(2);
            step(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
